conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Raster-scan sliding-window generator directly upstream of ConvLayer_calc.
- Accepts one N-bit pixel per enabled cycle and buffers KERNEL-1 image lines.
- Emits each fully-populated KERNEL x KERNEL window as a flat data2conv vector with a one-cycle en_out strobe; these connect straight to ConvLayer_calc's data2conv/en_in.
- Valid (no-padding) convolution only: (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1) windows per frame.

Parameters:
- KERNEL, 3, window side (1/3/5/7); must satisfy KERNEL <= IMG_W and KERNEL <= IMG_H.
- N, 4, pixel width, equal to ConvLayer_calc N.
- IMG_W, 8, pixels per line.
- IMG_H, 8, lines per frame.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- d_in, input, N, pixel in raster order, row-major, left to right.
- en_in, input, 1, d_in valid this cycle; pixel consumed when high, no back-pressure.
- data2conv, output, KERNEL*KERNEL*N, window; element i = r*KERNEL+c at [i*N +: N].
- en_out, output, 1, one-cycle strobe: data2conv holds a new valid window.
- last_out, output, 1, high together with en_out on the final window of a frame.

Behaviour:
- Reset, synchronous, rst high at posedge:
  - col=0, row=0; en_out=0, last_out=0, data2conv=0.
  - Window registers and line buffers cleared to 0.
  - rst overrides en_in in the same cycle; the partial frame is discarded and the next accepted pixel is (0,0).
- Counters (width $clog2 of IMG_W / IMG_H):
  - Advance only on en_in.
  - col wraps IMG_W-1 -> 0 and increments row.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next pixel starts a new frame. No idle cycles are required between frames.
- Line buffers:
  - KERNEL-1 cascaded single-line delays of IMG_W entries, shifting only on en_in.
  - Tap k (k=1..KERNEL-1) gives the pixel at the same column, k rows earlier.
- Window update on en_in:
  - Every window row shifts one column left: win[r][c] <= win[r][c+1].
  - New right column: win[KERNEL-1][KERNEL-1] <= d_in, and win[r][KERNEL-1] <= tap(KERNEL-1-r).
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- Emission:
  - en_out is registered. It is high in the cycle after an accepted pixel whose pre-increment (row, col) satisfies row >= KERNEL-1 and col >= KERNEL-1.
  - Latency: 1 clock from the completing pixel.
  - last_out = en_out AND the completing pixel was (IMG_H-1, IMG_W-1).
- Holding behaviour:
  - en_in low: no state change, en_out=0, data2conv holds its last value.
  - Gaps in en_in are allowed anywhere, including across line and frame boundaries. The window sequence is identical to the gap-free case.
- Boundaries:
  - At line wrap, stale columns from the previous line are never emitted because emission requires col >= KERNEL-1.
  - At frame wrap, the previous frame's rows are never emitted because emission requires row >= KERNEL-1.
- KERNEL=1: no line buffers. Every accepted pixel yields en_out the next cycle with data2conv=d_in.
- Data is moved only, never transformed: no arithmetic and no width change.

Decomposition:
- Shared package cnn_pkg:
  - Default KERNEL, N, IMG_W, IMG_H.
  - Function win_idx(r,c)=r*KERNEL+c.
  - Function clog2-based counter widths.
- One sub-module, conv_line_buffer:
  - Parameters N, DEPTH=IMG_W; ports clk, rst, en, d_in, d_out.
  - Shift-register delay line, cleared on rst.
  - Instantiated KERNEL-1 times in a generate loop.

Test Plan (KERNEL=3, N=4, IMG_W=5, IMG_H=4, pixel value = (row*5+col) mod 16, en_in continuous unless stated):
1. First window: stream 20 pixels -> first en_out one cycle after pixel index 12, with elements 0..8 = 0,1,2,5,6,7,10,11,12; exactly 6 en_out pulses per frame.
2. Last window: same stream -> 6th window = 7,8,9,12,13,14,1,2,3 with last_out=1; last_out=0 on the other 5.
3. Stalls: en_in high every other cycle -> same 6 windows in the same order; en_out never high on two consecutive cycles; data2conv holds between strobes.
4. Reset mid-frame: 8 pixels, rst for 1 cycle, then a fresh frame -> no en_out before the 13th post-reset pixel; first window again 0,1,2,5,6,7,10,11,12.
5. Back-to-back frames: 40 pixels with no gap -> 12 windows; second frame's first window = 0,1,2,5,6,7,10,11,12, with no leakage from frame 1; two last_out pulses.
6. KERNEL=1: stream 0..19 -> 20 en_out pulses, data2conv = previous d_in each time; last_out on value 3 (index 19).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared defaults and helpers for the CNN front-end blocks.
package cnn_pkg;

  localparam int DEF_KERNEL = 3;
  localparam int DEF_N      = 4;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;

  // Flat window element index for row r, column c of a k x k window.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-line delay: d_out is the value seen on d_in DEPTH enabled cycles ago.
module conv_line_buffer #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] d_out
);

  logic [DEPTH-1:0][N-1:0] mem_r;

  // Shift register advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r <= '0;
    end else if (en) begin
      mem_r[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end else begin
      mem_r <= mem_r;
    end
  end

  assign d_out = mem_r[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan KERNEL x KERNEL sliding-window generator (valid convolution, no padding).
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int KERNEL = DEF_KERNEL,
  parameter int N      = DEF_N,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               d_in,
  input  logic                       en_in,
  output logic [KERNEL*KERNEL*N-1:0] data2conv,
  output logic                       en_out,
  output logic                       last_out
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int KK = KERNEL * KERNEL;

  logic [CW-1:0]            col_r;
  logic [RW-1:0]            row_r;
  logic [KERNEL-1:0][N-1:0] tap_s;
  logic [KK-1:0][N-1:0]     win_r;
  logic [KK-1:0][N-1:0]     win_nxt_s;
  logic                     emit_s;
  logic                     frame_end_s;

  // tap_s[k] is the pixel at the current column, k rows earlier.
  assign tap_s[0] = d_in;

  for (genvar k = 1; k < KERNEL; k++) begin : g_lb
    conv_line_buffer #(
      .N     (N),
      .DEPTH (IMG_W)
    ) u_lb (
      .clk   (clk),
      .rst   (rst),
      .en    (en_in),
      .d_in  (tap_s[k-1]),
      .d_out (tap_s[k])
    );
  end

  // Next window: shift every row left and load the new right column from the taps.
  always_comb begin
    win_nxt_s = win_r;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        win_nxt_s[win_idx(r, c, KERNEL)] = win_r[win_idx(r, c + 1, KERNEL)];
      end
      win_nxt_s[win_idx(r, KERNEL - 1, KERNEL)] = tap_s[KERNEL-1-r];
    end
  end

  assign emit_s      = (int'(row_r) >= KERNEL - 1) && (int'(col_r) >= KERNEL - 1);
  assign frame_end_s = (row_r == RW'(IMG_H - 1)) && (col_r == CW'(IMG_W - 1));

  // Raster counters, window state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r     <= '0;
      row_r     <= '0;
      win_r     <= '0;
      data2conv <= '0;
      en_out    <= 1'b0;
      last_out  <= 1'b0;
    end else if (en_in) begin
      win_r    <= win_nxt_s;
      en_out   <= emit_s;
      last_out <= emit_s && frame_end_s;
      if (emit_s) begin
        data2conv <= win_nxt_s;
      end else begin
        data2conv <= data2conv;
      end
      if (col_r == CW'(IMG_W - 1)) begin
        col_r <= '0;
        if (row_r == RW'(IMG_H - 1)) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else begin
      en_out   <= 1'b0;
      last_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized and directed checks of conv_window_gen (KERNEL=3 and KERNEL=1) against an image-array model.
module tb_conv_window_gen;

  localparam int N = 4;
  localparam int W = 5;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] d_in;
  logic         en_in;
  logic [35:0]  data3;
  logic         en3, last3;
  logic [3:0]   data1;
  logic         en1, last1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: frame image, raster position, expected outputs
  logic [N-1:0] img [H][W];
  int           prow, pcol;
  logic [35:0]  exp_d3;
  logic         exp_en3, exp_last3;
  logic [3:0]   exp_d1;
  logic         exp_en1, exp_last1;
  int           win_cnt, last_cnt;

  always #5 clk = ~clk;

  conv_window_gen #(.KERNEL(3), .N(N), .IMG_W(W), .IMG_H(H)) u_dut3 (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .data2conv(data3), .en_out(en3), .last_out(last3)
  );

  conv_window_gen #(.KERNEL(1), .N(N), .IMG_W(W), .IMG_H(H)) u_dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .data2conv(data1), .en_out(en1), .last_out(last1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, let the DUT sample, update the model, compare.
  task automatic step(input logic r, input logic e, input logic [N-1:0] d);
    @(negedge clk);
    rst   = r;
    en_in = e;
    d_in  = d;
    @(posedge clk);
    #1;
    if (r) begin
      prow = 0; pcol = 0;
      exp_en3 = 1'b0; exp_last3 = 1'b0; exp_d3 = '0;
      exp_en1 = 1'b0; exp_last1 = 1'b0; exp_d1 = '0;
    end else if (e) begin
      img[prow][pcol] = d;
      exp_en3 = (prow >= 2) && (pcol >= 2);
      exp_last3 = exp_en3 && (prow == H - 1) && (pcol == W - 1);
      if (exp_en3) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            exp_d3[(rr*3+cc)*N +: N] = img[prow-2+rr][pcol-2+cc];
      end
      exp_en1   = 1'b1;
      exp_last1 = (prow == H - 1) && (pcol == W - 1);
      exp_d1    = d;
      if (pcol == W - 1) begin
        pcol = 0;
        prow = (prow == H - 1) ? 0 : prow + 1;
      end else begin
        pcol++;
      end
    end else begin
      exp_en3 = 1'b0; exp_last3 = 1'b0;
      exp_en1 = 1'b0; exp_last1 = 1'b0;
    end
    check_eq("k3_en_out",    64'(en3),   64'(exp_en3));
    check_eq("k3_last_out",  64'(last3), 64'(exp_last3));
    check_eq("k3_data2conv", 64'(data3), 64'(exp_d3));
    check_eq("k1_en_out",    64'(en1),   64'(exp_en1));
    check_eq("k1_last_out",  64'(last1), 64'(exp_last1));
    check_eq("k1_data2conv", 64'(data1), 64'(exp_d1));
    if (en3) win_cnt++;
    if (last3) last_cnt++;
  endtask

  function automatic logic [N-1:0] pat();
    return N'((prow * W + pcol) % 16);
  endfunction

  initial begin
    rst = 1'b1; en_in = 1'b0; d_in = '0;
    prow = 0; pcol = 0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        img[i][j] = '0;

    step(1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b0, 4'h0);

    // two back-to-back frames of the pattern image
    win_cnt = 0; last_cnt = 0;
    for (int i = 0; i < 2 * W * H; i++) step(1'b0, 1'b1, pat());
    step(1'b0, 1'b0, 4'h0);
    check_eq("b2b_windows", 64'(win_cnt), 64'd12);
    check_eq("b2b_last",    64'(last_cnt), 64'd2);

    // en_in every other cycle
    win_cnt = 0; last_cnt = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b0, 1'b1, pat());
      step(1'b0, 1'b0, 4'($urandom));
    end
    check_eq("stall_windows", 64'(win_cnt), 64'd6);
    check_eq("stall_last",    64'(last_cnt), 64'd1);

    // reset mid-frame then a fresh frame
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'($urandom));
    step(1'b1, 1'b1, 4'($urandom));
    win_cnt = 0; last_cnt = 0;
    for (int i = 0; i < W * H; i++) step(1'b0, 1'b1, pat());
    step(1'b0, 1'b0, 4'h0);
    check_eq("rst_windows", 64'(win_cnt), 64'd6);

    // random data, random gaps, occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
